// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl
// Purpose  : Multi-cycle radix-2 restoring divider sequencer for RV32M
//            DIV/DIVU/REM/REMU. It stalls EX until a one-cycle done strobe.
// Options  : DIV_REM_FUSE_EN - keep the last result so that a repeated
//            operand pair (the DIV-then-REM idiom) finishes in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] div_in1,
    input  logic [XLEN-1:0] div_in2,
    input  logic            flush,
    output logic [XLEN-1:0] div_out,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    localparam logic [4:0] OP_DIV  = 5'b10110;
    localparam logic [4:0] OP_DIVU = 5'b10111;
    localparam logic [4:0] OP_REM  = 5'b11000;
    localparam logic [4:0] OP_REMU = 5'b11001;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, next_state;

    // Operation decode of the shared ALU control bus
    logic valid_op, in_signed, in_is_rem;
    logic div_zero, overflow, special, hit;
    logic [XLEN-1:0] abs_in1, abs_in2, spec_quo, spec_rem;

    assign valid_op  = (alu_control == OP_DIV)  || (alu_control == OP_DIVU) ||
                       (alu_control == OP_REM)  || (alu_control == OP_REMU);
    assign in_signed = (alu_control == OP_DIV)  || (alu_control == OP_REM);
    assign in_is_rem = (alu_control == OP_REM)  || (alu_control == OP_REMU);
    assign div_zero  = (div_in2 == '0);
    assign overflow  = in_signed && (div_in1 == INT_MIN) && (div_in2 == ALL_ONES);
    assign abs_in1   = (in_signed && div_in1[XLEN-1]) ? -div_in1 : div_in1;
    assign abs_in2   = (in_signed && div_in2[XLEN-1]) ? -div_in2 : div_in2;
    assign spec_quo  = div_zero ? ALL_ONES : INT_MIN;
    assign spec_rem  = div_zero ? div_in1  : '0;
    assign special   = div_zero || overflow || hit;

    // Iteration datapath registers
    logic [XLEN-1:0]  quo, rem, dvs;
    logic [CNT_W-1:0] counter;
    logic             sign_q, sign_r, op_rem;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] quo_nxt, rem_nxt, quo_fix, rem_fix;
    logic            last_iter;

    assign rem_sh    = {rem, quo[XLEN-1]};
    assign trial     = rem_sh - {1'b0, dvs};
    assign quo_nxt   = {quo[XLEN-2:0], ~trial[XLEN]};
    assign rem_nxt   = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_fix   = sign_q ? -quo_nxt : quo_nxt;
    assign rem_fix   = (sign_r && (rem_nxt != '0)) ? -rem_nxt : rem_nxt;
    assign last_iter = (counter == LAST_CNT);

`ifdef DIV_REM_FUSE_EN
    logic            cache_valid, cache_signed;
    logic [XLEN-1:0] cache_in1, cache_in2, cache_quo, cache_rem;

    assign hit = cache_valid && (div_in1 == cache_in1) &&
                 (div_in2 == cache_in2) && (in_signed == cache_signed);
`else
    assign hit = 1'b0;
`endif

    assign busy  = (state != IDLE);
    assign stall = start && valid_op && !done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush always wins
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!flush && start && valid_op) begin
                    next_state = special ? FIN : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (last_iter) begin
                    next_state = FIN;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, iteration, result register and done strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_out <= '0;
            done    <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            counter <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            op_rem  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (start && valid_op) begin
                            if (hit) begin
`ifdef DIV_REM_FUSE_EN
                                div_out <= in_is_rem ? cache_rem : cache_quo;
`endif
                                done    <= 1'b1;
                            end else if (div_zero || overflow) begin
                                div_out <= in_is_rem ? spec_rem : spec_quo;
                                done    <= 1'b1;
                            end else begin
                                quo     <= abs_in1;
                                dvs     <= abs_in2;
                                rem     <= '0;
                                counter <= '0;
                                sign_q  <= in_signed && (div_in1[XLEN-1] ^ div_in2[XLEN-1]);
                                sign_r  <= in_signed && div_in1[XLEN-1];
                                op_rem  <= in_is_rem;
                            end
                        end
                    end
                    CALC: begin
                        quo     <= quo_nxt;
                        rem     <= rem_nxt;
                        counter <= counter + CNT_W'(1);
                        if (last_iter) begin
                            div_out <= op_rem ? rem_fix : quo_fix;
                            done    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DIV_REM_FUSE_EN
    // Last-result cache: key captured on accept, marked valid on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_in1    <= '0;
            cache_in2    <= '0;
            cache_quo    <= '0;
            cache_rem    <= '0;
        end else if (flush) begin
            cache_valid <= 1'b0;
        end else if (state == IDLE && start && valid_op && !hit) begin
            cache_in1    <= div_in1;
            cache_in2    <= div_in2;
            cache_signed <= in_signed;
            if (div_zero || overflow) begin
                cache_quo   <= spec_quo;
                cache_rem   <= spec_rem;
                cache_valid <= 1'b1;
            end else begin
                cache_valid <= 1'b0;
            end
        end else if (state == CALC && last_iter) begin
            cache_quo   <= quo_fix;
            cache_rem   <= rem_fix;
            cache_valid <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq_ctrl
// Purpose  : Directed, table-driven bench for div_seq_ctrl with hand-written
//            flush, priority, invalid-op and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam logic [4:0] DIV  = 5'b10110;
    localparam logic [4:0] DIVU = 5'b10111;
    localparam logic [4:0] REM  = 5'b11000;
    localparam logic [4:0] REMU = 5'b11001;

`ifdef DIV_REM_FUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  alu_control = 5'b00000;
    logic [31:0] div_in1 = '0;
    logic [31:0] div_in2 = '0;
    logic        flush = 1'b0;
    logic [31:0] div_out;
    logic        done, busy, stall;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .div_in1(div_in1), .div_in2(div_in2), .flush(flush),
        .div_out(div_out), .done(done), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, wait for done (bounded)
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic stall_done);
        @(negedge clk);
        alu_control = op;
        div_in1     = a;
        div_in2     = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        div_in1 = ~a;
        div_in2 = b ^ 32'h5A5A_0F0F;
        lat = 0;
        res = '0;
        stall_done = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = c;
                res = div_out;
                stall_done = stall;
                break;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] res;
    int          lat;
    logic        sd;
    int          done_seen;

    initial begin
        vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,          33};
        vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,           HIT_LAT};
        vecs[2]  = '{DIV,  -32'sd100,      32'd7,          32'hFFFF_FFF2,   33};
        vecs[3]  = '{REM,  -32'sd100,      32'd7,          32'hFFFF_FFFE,   HIT_LAT};
        vecs[4]  = '{REM,  32'd100,        -32'sd7,        32'd2,           33};
        vecs[5]  = '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,   1};
        vecs[6]  = '{REMU, 32'd5,          32'd0,          32'd5,           1};
        vecs[7]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1};
        vecs[8]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           1};
        vecs[9]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,   33};
        vecs[10] = '{REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,           33};
        vecs[11] = '{DIVU, 32'd7,          32'd100,        32'd0,           33};
        vecs[12] = '{DIV,  -32'sd7,        -32'sd2,        32'd3,           33};
        vecs[13] = '{REM,  -32'sd7,        -32'sd2,        32'hFFFF_FFFF,   HIT_LAT};

        // Reset state
        #12;
        check("reset_div_out", div_out, 32'd0);
        check("reset_done",    {31'd0, done},  32'd0);
        check("reset_busy",    {31'd0, busy},  32'd0);
        check("reset_stall",   {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven ops
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, sd);
            check($sformatf("vec%0d_out", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_stall_at_done", i), {31'd0, sd}, 32'd0);
        end

        // Non-divide op code is ignored
        @(negedge clk);
        alu_control = 5'b00000;
        div_in1 = 32'd9;
        div_in2 = 32'd3;
        start = 1'b1;
        #1;
        check("invalid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        check("invalid_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;

        // Flush mid-CALC: DIVU 1000/3, flush during cycle 10
        @(negedge clk);
        alu_control = DIVU;
        div_in1 = 32'd1000;
        div_in2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy_c1", {31'd0, busy}, 32'd1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy_c11", {31'd0, busy}, 32'd0);
        check("flush_done_c11", {31'd0, done}, 32'd0);
        flush = 1'b0;
        start = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("flush_no_done", 32'(done_seen), 32'd0);

        // Flush has priority over accept in IDLE
        @(negedge clk);
        alu_control = DIVU;
        div_in1 = 32'd50;
        div_in2 = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_prio_busy", {31'd0, busy}, 32'd0);
        check("flush_prio_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        flush = 1'b0;

        run_op(DIVU, 32'd9, 32'd2, res, lat, sd);
        check("after_flush_out", res, 32'd4);
        check("after_flush_lat", 32'(lat), 32'd33);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        alu_control = DIVU;
        div_in1 = 32'd1000;
        div_in2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_div_out", div_out, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_op(DIVU, 32'd9, 32'd2, res, lat, sd);
        check("after_rst_out", res, 32'd4);
        check("after_rst_lat", 32'(lat), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
